// File: rtl/cart_mapper_detect.sv
// rtl/cart_mapper_detect.sv - classifies a loaded cartridge ROM's bank-switch mapper by scanning for LD (nn),A writes
module cart_mapper_detect #(
    parameter int ADDR_W     = 22,
    parameter int SCAN_BYTES = 32768
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W:0]   rom_size,
    output logic              mem_rd,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic              mem_ready,
    input  logic [7:0]        mem_data,
    output logic              busy,
    output logic              done,
    output logic [5:0]        mapper
);

    localparam logic [5:0] MAPPER_LINEAR     = 6'd0;
    localparam logic [5:0] MAPPER_KONAMI     = 6'd1;
    localparam logic [5:0] MAPPER_KONAMI_SCC = 6'd2;
    localparam logic [5:0] MAPPER_ASCII8     = 6'd3;
    localparam logic [5:0] MAPPER_ASCII16    = 6'd4;

    localparam logic [ADDR_W:0] SMALL_MAX = (ADDR_W+1)'(32'h10000);
    localparam logic [ADDR_W:0] SCAN_MAX  = (ADDR_W+1)'(SCAN_BYTES);

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_GAP, S_DECIDE, S_FIN} state_t;

    state_t          state;
    logic [7:0]      w0, w1, w2;
    logic [1:0]      rx_cnt;
    logic [7:0]      cnt_scc, cnt_kon, cnt_a8, cnt_a16;
    logic [ADDR_W:0] scan_limit;
    logic [5:0]      result;

    logic [15:0]     op_addr;
    logic            hit_scc, hit_kon, hit_a8, hit_a16;
    logic [5:0]      pick;
    logic [7:0]      pick_val;

    function automatic logic [7:0] sat_inc(input logic [7:0] v, input logic en);
        return (en && v != 8'hFF) ? v + 8'd1 : v;
    endfunction

    // Window holds opcode (w0) and little-endian target address (w1 low, w2 high)
    always_comb begin
        op_addr = {w2, w1};
        hit_scc = 1'b0;
        hit_kon = 1'b0;
        hit_a8  = 1'b0;
        hit_a16 = 1'b0;
        if (rx_cnt == 2'd3 && w0 == 8'h32) begin
            case (op_addr)
                16'h5000, 16'h9000, 16'hB000: hit_scc = 1'b1;
                16'h4000, 16'h8000, 16'hA000: hit_kon = 1'b1;
                16'h6800, 16'h7800:           hit_a8  = 1'b1;
                16'h6000: begin hit_kon = 1'b1; hit_a8 = 1'b1; hit_a16 = 1'b1; end
                16'h7000: begin hit_scc = 1'b1; hit_a8 = 1'b1; hit_a16 = 1'b1; end
                16'h77FF:                     hit_a16 = 1'b1;
                default: ;
            endcase
        end
    end

    // Strict greater-than keeps the earlier (higher priority) candidate on ties
    always_comb begin
        pick     = MAPPER_KONAMI_SCC;
        pick_val = cnt_scc;
        if (cnt_kon > pick_val) begin pick = MAPPER_KONAMI;  pick_val = cnt_kon; end
        if (cnt_a8  > pick_val) begin pick = MAPPER_ASCII8;  pick_val = cnt_a8;  end
        if (cnt_a16 > pick_val) begin pick = MAPPER_ASCII16; pick_val = cnt_a16; end
        if (pick_val == 8'd0) pick = MAPPER_LINEAR;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            mem_rd     <= 1'b0;
            mem_addr   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            mapper     <= MAPPER_LINEAR;
            result     <= MAPPER_LINEAR;
            w0         <= 8'd0;
            w1         <= 8'd0;
            w2         <= 8'd0;
            rx_cnt     <= 2'd0;
            cnt_scc    <= 8'd0;
            cnt_kon    <= 8'd0;
            cnt_a8     <= 8'd0;
            cnt_a16    <= 8'd0;
            scan_limit <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    busy <= 1'b0;
                    if (start) begin
                        busy <= 1'b1;
                        if (rom_size <= SMALL_MAX) begin
                            result <= MAPPER_LINEAR;
                            state  <= S_FIN;
                        end else begin
                            w0         <= 8'd0;
                            w1         <= 8'd0;
                            w2         <= 8'd0;
                            rx_cnt     <= 2'd0;
                            cnt_scc    <= 8'd0;
                            cnt_kon    <= 8'd0;
                            cnt_a8     <= 8'd0;
                            cnt_a16    <= 8'd0;
                            scan_limit <= (rom_size < SCAN_MAX) ? rom_size : SCAN_MAX;
                            mem_addr   <= '0;
                            state      <= S_FETCH;
                        end
                    end
                end
                S_FETCH: begin
                    mem_rd <= 1'b1;
                    state  <= S_WAIT;
                end
                S_WAIT: begin
                    if (mem_ready) begin
                        mem_rd   <= 1'b0;
                        w0       <= w1;
                        w1       <= w2;
                        w2       <= mem_data;
                        mem_addr <= mem_addr + ADDR_W'(1);
                        if (rx_cnt != 2'd3) rx_cnt <= rx_cnt + 2'd1;
                        state    <= S_GAP;
                    end
                end
                S_GAP: begin
                    cnt_scc <= sat_inc(cnt_scc, hit_scc);
                    cnt_kon <= sat_inc(cnt_kon, hit_kon);
                    cnt_a8  <= sat_inc(cnt_a8,  hit_a8);
                    cnt_a16 <= sat_inc(cnt_a16, hit_a16);
                    state   <= ({1'b0, mem_addr} == scan_limit) ? S_DECIDE : S_FETCH;
                end
                S_DECIDE: begin
                    result <= pick;
                    state  <= S_FIN;
                end
                S_FIN: begin
                    done   <= 1'b1;
                    mapper <= result;
                    state  <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule
